// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory-wait freezes, branch flushes,
// RAW hazard bubbles, memory timeout detection and saturating performance counters.
module phc_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;

  assign cnt_o = cnt_q;
endmodule

module pipe_hazard_ctrl #(
  parameter int FWD_EN      = 1,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       id_rn,
  input  logic [3:0]       id_rm,
  input  logic             id_use_rn,
  input  logic             id_use_rm,
  input  logic [3:0]       exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_memr_en,
  input  logic [3:0]       mem_dest,
  input  logic             mem_wb_en,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             if_freeze,
  output logic             ifid_freeze,
  output logic             ifid_flush,
  output logic             idex_freeze,
  output logic             idex_flush,
  output logic             exmem_freeze,
  output logic             memwb_bubble,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);
  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_ERR} state_t;

  state_t     state_q;
  logic [7:0] wait_cnt_q;
  logic       mem_err_q;

  logic mem_stall, br_apply, hit_exe, hit_mem, raw_haz, data_haz;

  assign mem_stall = mem_req & ~mem_ready;
  assign hit_exe   = exe_wb_en & ((id_use_rn & (id_rn == exe_dest)) |
                                  (id_use_rm & (id_rm == exe_dest)));
  assign hit_mem   = mem_wb_en & ((id_use_rn & (id_rn == mem_dest)) |
                                  (id_use_rm & (id_rm == mem_dest)));
  assign raw_haz   = (FWD_EN != 0) ? (hit_exe & exe_memr_en) : (hit_exe | hit_mem);

  // A branch held through a memory stall is still sitting in frozen EXE, so it
  // naturally fires once, on the first unstalled cycle.
  assign br_apply  = ~rst & branch_taken & ~mem_stall;
  assign data_haz  = ~rst & raw_haz & ~branch_taken & ~mem_stall;

  // rst gates the controls so a stall in progress releases at once.
  assign if_freeze    = (~rst & mem_stall) | data_haz;
  assign ifid_freeze  = (~rst & mem_stall) | data_haz;
  assign idex_freeze  = ~rst & mem_stall;
  assign exmem_freeze = ~rst & mem_stall;
  assign memwb_bubble = ~rst & mem_stall;
  assign ifid_flush   = br_apply;
  assign idex_flush   = br_apply | data_haz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      case (state_q)
        S_RUN:
          if (mem_stall) begin
            wait_cnt_q <= 8'd1;
            if (TIMEOUT <= 8'd1) begin
              mem_err_q <= 1'b1;
              state_q   <= S_ERR;
            end else begin
              state_q   <= S_WAIT;
            end
          end
        S_WAIT:
          if (mem_ready || !mem_req) begin
            state_q    <= S_RUN;
            wait_cnt_q <= '0;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
            if (wait_cnt_q + 8'd1 >= TIMEOUT) begin
              mem_err_q <= 1'b1;
              state_q   <= S_ERR;
            end
          end
        default: state_q <= S_ERR;
      endcase
    end
  end

  assign mem_err = mem_err_q;

  phc_sat_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst(rst), .inc_i(if_freeze), .cnt_o(stall_cycles)
  );
  phc_sat_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst(rst), .inc_i(ifid_flush), .cnt_o(flush_events)
  );
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: one forwarding instance (timeout 4) and one non-forwarding
// instance (3-bit counters) driven in parallel, checked through a scoreboard queue.
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0] id_rn, id_rm, exe_dest, mem_dest;
  logic id_use_rn, id_use_rm, exe_wb_en, exe_memr_en, mem_wb_en;
  logic branch_taken, mem_req, mem_ready;

  logic a_iff, a_ifidfr, a_ifidfl, a_idexfr, a_idexfl, a_exmfr, a_mwb, a_err;
  logic b_iff, b_ifidfr, b_ifidfl, b_idexfr, b_idexfl, b_exmfr, b_mwb, b_err;
  logic [15:0] a_stall, a_flush;
  logic [2:0]  b_stall, b_flush;

  pipe_hazard_ctrl #(.FWD_EN(1), .MEM_TIMEOUT(4), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .id_rn(id_rn), .id_rm(id_rm), .id_use_rn(id_use_rn),
    .id_use_rm(id_use_rm), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
    .exe_memr_en(exe_memr_en), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .if_freeze(a_iff), .ifid_freeze(a_ifidfr), .ifid_flush(a_ifidfl),
    .idex_freeze(a_idexfr), .idex_flush(a_idexfl), .exmem_freeze(a_exmfr),
    .memwb_bubble(a_mwb), .mem_err(a_err), .stall_cycles(a_stall), .flush_events(a_flush)
  );

  pipe_hazard_ctrl #(.FWD_EN(0), .MEM_TIMEOUT(15), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst), .id_rn(id_rn), .id_rm(id_rm), .id_use_rn(id_use_rn),
    .id_use_rm(id_use_rm), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
    .exe_memr_en(exe_memr_en), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .if_freeze(b_iff), .ifid_freeze(b_ifidfr), .ifid_flush(b_ifidfl),
    .idex_freeze(b_idexfr), .idex_flush(b_idexfl), .exmem_freeze(b_exmfr),
    .memwb_bubble(b_mwb), .mem_err(b_err), .stall_cycles(b_stall), .flush_events(b_flush)
  );

  // Control vector: {if_fr, ifid_fr, ifid_fl, idex_fr, idex_fl, exmem_fr, memwb_bub}
  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_HAZ  = 7'b1100100;
  localparam logic [6:0] C_BR   = 7'b0010100;
  localparam logic [6:0] C_MEM  = 7'b1101011;

  wire [6:0] ctl_a = {a_iff, a_ifidfr, a_ifidfl, a_idexfr, a_idexfl, a_exmfr, a_mwb};
  wire [6:0] ctl_b = {b_iff, b_ifidfr, b_ifidfl, b_idexfr, b_idexfl, b_exmfr, b_mwb};

  typedef struct {
    string       tag;
    int          sig;
    logic [15:0] val;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  int   st_a = 0, fl_a = 0, st_b = 0, fl_b = 0;
  bit   err_a = 0, err_b = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] obs(input int sig);
    case (sig)
      0:       return {9'd0, ctl_a};
      1:       return {9'd0, ctl_b};
      2:       return {15'd0, a_err};
      3:       return a_stall;
      4:       return a_flush;
      5:       return {15'd0, b_err};
      6:       return {13'd0, b_stall};
      default: return {13'd0, b_flush};
    endcase
  endfunction

  task automatic push(input string tag, input int sig, input logic [15:0] v);
    exp_t e;
    e.tag = tag; e.sig = sig; e.val = v;
    sbq.push_back(e);
  endtask

  task automatic clr();
    id_rn = 0; id_rm = 0; id_use_rn = 0; id_use_rm = 0;
    exe_dest = 0; exe_wb_en = 0; exe_memr_en = 0;
    mem_dest = 0; mem_wb_en = 0;
    branch_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic load_use();
    exe_memr_en = 1; exe_wb_en = 1; exe_dest = 4'd3; id_rn = 4'd3; id_use_rn = 1;
  endtask

  // Inputs are already applied; queue expectations, compare mid-cycle, then advance.
  task automatic step(input string tag, input logic [6:0] ea, input logic [6:0] eb);
    push({tag, ".errA"},   2, {15'd0, err_a});
    push({tag, ".stallA"}, 3, 16'(st_a));
    push({tag, ".flushA"}, 4, 16'(fl_a));
    push({tag, ".errB"},   5, {15'd0, err_b});
    push({tag, ".stallB"}, 6, 16'(st_b));
    push({tag, ".flushB"}, 7, 16'(fl_b));
    push({tag, ".ctlA"},   0, {9'd0, ea});
    push({tag, ".ctlB"},   1, {9'd0, eb});
    @(negedge clk);
    while (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk(e.tag, obs(e.sig), e.val);
    end
    if (!rst) begin
      if (ea[6] && st_a < 65535) st_a++;
      if (ea[4] && fl_a < 65535) fl_a++;
      if (eb[6] && st_b < 7) st_b++;
      if (eb[4] && fl_b < 7) fl_b++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1;
    clr();
    #1;
    step("reset", C_NONE, C_NONE);
    rst = 0;
    step("idle", C_NONE, C_NONE);

    load_use();
    step("loaduse", C_HAZ, C_HAZ);
    clr();
    step("lu_done", C_NONE, C_NONE);

    load_use(); exe_memr_en = 0;
    step("alu_raw", C_NONE, C_HAZ);
    clr();
    step("alu_done", C_NONE, C_NONE);

    mem_wb_en = 1; mem_dest = 4'd5; id_rm = 4'd5; id_use_rm = 1;
    step("mem_raw", C_NONE, C_HAZ);
    id_use_rm = 0;
    step("mem_nouse", C_NONE, C_NONE);
    clr();

    load_use(); branch_taken = 1;
    step("br_haz", C_BR, C_BR);
    clr();
    step("br_done", C_NONE, C_NONE);

    mem_req = 1; branch_taken = 1;
    for (int i = 0; i < 3; i++) step("memwait_br", C_MEM, C_MEM);
    mem_ready = 1;
    step("mem_ready_br", C_BR, C_BR);
    clr();
    step("after_br", C_NONE, C_NONE);

    mem_req = 1; mem_ready = 1;
    step("zero_wait", C_NONE, C_NONE);

    mem_ready = 0;
    for (int k = 0; k < 5; k++) begin
      step("timeout", C_MEM, C_MEM);
      if (k == 3) err_a = 1;
    end
    mem_ready = 1;
    step("err_sticky", C_NONE, C_NONE);
    clr();
    step("err_idle", C_NONE, C_NONE);

    mem_req = 1;
    step("pre_rst", C_MEM, C_MEM);
    rst = 1;
    st_a = 0; fl_a = 0; st_b = 0; fl_b = 0; err_a = 0; err_b = 0;
    step("rst_mid", C_NONE, C_NONE);
    rst = 0;
    for (int i = 0; i < 3; i++) step("post_rst", C_MEM, C_MEM);
    clr();
    step("final", C_NONE, C_NONE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
